sipo_frame_ctrl: RTL
====================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter BW, default 8: sample width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 50: samples per row (one row per SIPO FIFO lane); at least 2.
REQ-003 SHALL have parameter VECTOR_LEN, default 8: rows per frame (number of SIPO lanes); at least 2.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port s_data_i, input, BW: upstream sample.
REQ-007 SHALL have port s_valid_i, input, 1: upstream sample valid.
REQ-008 SHALL have port s_ready_o, output, 1: upstream ready; a transfer occurs when s_valid_i && s_ready_o.
REQ-009 SHALL have port sipo_data_o, output, BW: sample to SIPO data input.
REQ-010 SHALL have port sipo_valid_o, output, 1: sample valid to SIPO.
REQ-011 SHALL have port sipo_last_o, output, 1: last sample of current row to SIPO.
REQ-012 SHALL have port sipo_valid_i, input, 1: SIPO parallel-output valid (monitored).
REQ-013 SHALL have port sipo_last_i, input, 1: SIPO parallel-output last (monitored).
REQ-014 SHALL have port frame_done_o, output, 1: one-cycle pulse when the SIPO finishes draining a frame.
REQ-015 SHALL have port busy_o, output, 1: high while not in FILL.
REQ-016 SHALL have port row_o, output, clog2(VECTOR_LEN): current row index.
REQ-017 SHALL have port err_o, output, 1: sticky protocol error.

Function
REQ-018 SHALL implement states FILL and DRAIN; reset state is FILL.
REQ-019 In FILL, s_ready_o SHALL be 1; in DRAIN, s_ready_o SHALL be 0 (combinational from state only).
REQ-020 SHALL keep sample counter samp (width clog2(FRAME_LEN), range 0..FRAME_LEN-1) and row counter row (range 0..VECTOR_LEN-1).
REQ-021 On each transfer, SHALL register s_data_i into sipo_data_o and assert sipo_valid_o on the next cycle (latency 1); with no transfer, sipo_valid_o SHALL be 0 and sipo_data_o SHALL hold.
REQ-022 sipo_last_o SHALL be registered alongside sipo_valid_o: 1 iff the transferred sample had samp == FRAME_LEN-1; never high without sipo_valid_o.
REQ-023 On a transfer with samp < FRAME_LEN-1, SHALL increment samp; with samp == FRAME_LEN-1, SHALL wrap samp to 0 and advance row.
REQ-024 On a transfer with samp == FRAME_LEN-1 and row == VECTOR_LEN-1, SHALL wrap row to 0 and enter DRAIN on the next cycle; no further transfer is accepted on that following cycle.
REQ-025 In DRAIN, SHALL return to FILL in the cycle after sipo_valid_i && sipo_last_i and pulse frame_done_o for exactly that one cycle.
REQ-026 In DRAIN, sipo_valid_i without sipo_last_i SHALL be ignored; counters SHALL hold.
REQ-027 In FILL, any sipo_valid_i == 1 SHALL set err_o; err_o SHALL stay 1 until reset.
REQ-028 row_o SHALL equal the row counter; busy_o SHALL equal (state == DRAIN).
REQ-029 Gaps in s_valid_i SHALL not affect counting; only transfers advance samp and row.

Reset
REQ-030 While rst_n_i is 0, SHALL force state FILL, samp 0, row 0, sipo_valid_o 0, sipo_last_o 0, sipo_data_o 0, frame_done_o 0, err_o 0; s_ready_o SHALL read 1 once reset is released.
REQ-031 Reset asserted mid-frame or mid-drain SHALL discard all progress with no output pulses; the SIPO SHALL be reset by the same rst_n_i.

Verification (FRAME_LEN=50, VECTOR_LEN=8)
REQ-032 Continuous 400 samples, values 0..399 mod 256 -> sipo_valid_o 400 cycles at latency 1; sipo_last_o on samples 49,99,...,399; row_o steps 0..7 then wraps to 0; s_ready_o drops on the cycle after transfer 400.
REQ-033 In DRAIN, sipo_valid_i held for 50 cycles with sipo_last_i on the 50th -> frame_done_o 1-cycle pulse in the next cycle; s_ready_o 1 again in that cycle; busy_o 0.
REQ-034 Random s_valid_i with 30% gaps over 2 frames -> sipo_last_o count 16, frame_done_o count 2, no sample lost or duplicated.
REQ-035 s_valid_i held 1 during DRAIN -> no transfers, sipo_valid_o stays 0, samp/row unchanged.
REQ-036 sipo_valid_i pulsed at sample 10 in FILL -> err_o 1 and held through subsequent frames until rst_n_i.
REQ-037 rst_n_i asserted at sample 123 (row 2) -> outputs at reset values immediately; after release, the next sample is treated as samp 0 / row 0.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sipo_frame_ctrl
// Description : Feeds FRAME_LEN x VECTOR_LEN samples into a SIPO, then waits
//               for the SIPO to drain the frame before accepting more.
// Revision    : 1.0
// ============================================================================
module sipo_frame_ctrl #(
  parameter int BW         = 8,
  parameter int FRAME_LEN  = 50,
  parameter int VECTOR_LEN = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [BW-1:0]                 s_data_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  output logic [BW-1:0]                 sipo_data_o,
  output logic                          sipo_valid_o,
  output logic                          sipo_last_o,
  input  logic                          sipo_valid_i,
  input  logic                          sipo_last_i,
  output logic                          frame_done_o,
  output logic                          busy_o,
  output logic [$clog2(VECTOR_LEN)-1:0] row_o,
  output logic                          err_o
);

  localparam int SW = $clog2(FRAME_LEN);
  localparam int RW = $clog2(VECTOR_LEN);
  localparam logic [SW-1:0] SAMP_MAX = SW'(FRAME_LEN - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(VECTOR_LEN - 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   samp_q, samp_d;
  logic [RW-1:0]   row_q, row_d;
  logic [BW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            xfer;
  logic            samp_end;
  logic            row_end;
  logic            drain_end;

  assign s_ready_o = (state_q == FILL);
  assign xfer      = s_valid_i && s_ready_o;
  assign samp_end  = (samp_q == SAMP_MAX);
  assign row_end   = (row_q == ROW_MAX);
  assign drain_end = (state_q == DRAIN) && sipo_valid_i && sipo_last_i;

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    row_d   = row_q;
    data_d  = data_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      FILL: begin
        // The SIPO must stay silent while the frame is still being loaded.
        if (sipo_valid_i) err_d = 1'b1;
        if (xfer) begin
          data_d  = s_data_i;
          valid_d = 1'b1;
          last_d  = samp_end;
          if (samp_end) begin
            samp_d = '0;
            if (row_end) begin
              row_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_end) begin
          state_d = FILL;
          done_d  = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= FILL;
      samp_q  <= '0;
      row_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      row_q   <= row_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sipo_data_o  = data_q;
  assign sipo_valid_o = valid_q;
  assign sipo_last_o  = last_q;
  assign frame_done_o = done_q;
  assign busy_o       = (state_q == DRAIN);
  assign row_o        = row_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire
